// File: rtl/txfifo_pkg.sv
// Shared register map, response codes and FSM state types for the CPU transmit FIFO slave.
// No logic; constants only.
// No flow control of its own.
package txfifo_pkg;

    localparam logic [1:0] REG_DATA     = 2'd0;
    localparam logic [1:0] REG_STATUS   = 2'd1;
    localparam logic [1:0] REG_CTRL     = 2'd2;
    localparam logic [1:0] REG_UNMAPPED = 2'd3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int STAT_EMPTY_BIT   = 16;
    localparam int STAT_FULL_BIT    = 17;
    localparam int STAT_OVF_BIT     = 18;
    localparam int CTRL_FLUSH_BIT   = 0;
    localparam int CTRL_CLR_OVF_BIT = 1;

    typedef enum logic {W_IDLE, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head and one-cycle flush.
// Latency: a pushed word is visible at dout/level the cycle after the push.
// Backpressure: push while full is dropped unless a pop happens in the same cycle.
module sync_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 16,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          empty,
    output logic          full,
    output logic [LW-1:0] level
);

    localparam int PW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          do_push, do_pop;

    assign empty   = (level_q == '0);
    assign full    = (level_q == LW'(DEPTH));
    assign level   = level_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        // Flush wins over any same-cycle pop; pointers simply restart at zero.
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/axil_txfifo_slave.sv
// AXI-Lite slave: CPU pushes transmit words into a FIFO, reads status, issues flush/clear.
// Latency: B two cycles after a joint AW/W handshake; R one cycle after AR.
// Backpressure: one write and one read outstanding; B/R held until bready/rready.
module axil_txfifo_slave
    import txfifo_pkg::*;
#(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int DEPTH = 16,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   s_awaddr,
    input  logic            s_awvalid,
    output logic            s_awready,
    input  logic [DW-1:0]   s_wdata,
    input  logic [DW/8-1:0] s_wstrb,
    input  logic            s_wvalid,
    output logic            s_wready,
    output logic [1:0]      s_bresp,
    output logic            s_bvalid,
    input  logic            s_bready,
    input  logic [AW-1:0]   s_araddr,
    input  logic            s_arvalid,
    output logic            s_arready,
    output logic [DW-1:0]   s_rdata,
    output logic [1:0]      s_rresp,
    output logic            s_rvalid,
    input  logic            s_rready,
    output logic [DW-1:0]   tx_data,
    output logic            tx_valid,
    input  logic            tx_ready
);

    logic          ready_en_q, ready_en_d;
    w_state_e      w_state_q, w_state_d;
    logic          aw_held_q, aw_held_d;
    logic [1:0]    aw_reg_q, aw_reg_d;
    logic          w_held_q, w_held_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [1:0]    bresp_q, bresp_d;
    logic          ovf_q, ovf_d;
    r_state_e      r_state_q, r_state_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [1:0]    rresp_q, rresp_d;

    logic          fifo_push, fifo_flush, fifo_empty, fifo_full, tx_pop;
    logic [DW-1:0] fifo_dout, status_word;
    logic [LW-1:0] fifo_level;

    // Strobes and the address bits outside [3:2] carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{s_wstrb, s_awaddr[AW-1:4], s_awaddr[1:0],
                           s_araddr[AW-1:4], s_araddr[1:0]};

    sync_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .LW    (LW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (tx_ready),
        .flush (fifo_flush),
        .din   (wdata_q),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .level (fifo_level)
    );

    assign tx_data  = fifo_dout;
    assign tx_valid = !fifo_empty;
    assign tx_pop   = tx_ready && !fifo_empty;

    // ready_en_q keeps every ready low while reset is held and for the reset edge itself.
    assign s_awready = ready_en_q && (w_state_q == W_IDLE) && !aw_held_q;
    assign s_wready  = ready_en_q && (w_state_q == W_IDLE) && !w_held_q;
    assign s_bvalid  = (w_state_q == W_RESP);
    assign s_bresp   = bresp_q;
    assign s_arready = ready_en_q && (r_state_q == R_IDLE);
    assign s_rvalid  = (r_state_q == R_DATA);
    assign s_rdata   = rdata_q;
    assign s_rresp   = rresp_q;

    always_comb begin
        status_word                 = '0;
        status_word[LW-1:0]         = fifo_level;
        status_word[STAT_EMPTY_BIT] = fifo_empty;
        status_word[STAT_FULL_BIT]  = fifo_full;
        status_word[STAT_OVF_BIT]   = ovf_q;
    end

    always_comb begin
        ready_en_d = 1'b1;
        w_state_d  = w_state_q;
        aw_held_d  = aw_held_q;
        aw_reg_d   = aw_reg_q;
        w_held_d   = w_held_q;
        wdata_d    = wdata_q;
        bresp_d    = bresp_q;
        ovf_d      = ovf_q;
        fifo_push  = 1'b0;
        fifo_flush = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (s_awvalid && s_awready) begin
                    aw_held_d = 1'b1;
                    aw_reg_d  = s_awaddr[3:2];
                end
                if (s_wvalid && s_wready) begin
                    w_held_d = 1'b1;
                    wdata_d  = s_wdata;
                end
                // Register action fires one cycle after both halves are captured.
                if (aw_held_q && w_held_q) begin
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    w_state_d = W_RESP;
                    bresp_d   = RESP_OKAY;
                    case (aw_reg_q)
                        REG_DATA: begin
                            if (fifo_full && !tx_pop) begin
                                bresp_d = RESP_SLVERR;
                                ovf_d   = 1'b1;
                            end else begin
                                fifo_push = 1'b1;
                            end
                        end
                        REG_CTRL: begin
                            fifo_flush = wdata_q[CTRL_FLUSH_BIT];
                            if (wdata_q[CTRL_CLR_OVF_BIT]) begin
                                ovf_d = 1'b0;
                            end
                        end
                        REG_UNMAPPED: bresp_d = RESP_SLVERR;
                        default:      bresp_d = RESP_OKAY;
                    endcase
                end
            end
            W_RESP: begin
                if (s_bready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (r_state_q)
            R_IDLE: begin
                if (s_arvalid && s_arready) begin
                    r_state_d = R_DATA;
                    rdata_d   = '0;
                    rresp_d   = RESP_OKAY;
                    case (s_araddr[3:2])
                        REG_STATUS:   rdata_d = status_word;
                        REG_UNMAPPED: rresp_d = RESP_SLVERR;
                        default:      rdata_d = '0;
                    endcase
                end
            end
            R_DATA: begin
                if (s_rready) begin
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ready_en_q <= 1'b0;
            w_state_q  <= W_IDLE;
            aw_held_q  <= 1'b0;
            aw_reg_q   <= '0;
            w_held_q   <= 1'b0;
            wdata_q    <= '0;
            bresp_q    <= RESP_OKAY;
            ovf_q      <= 1'b0;
            r_state_q  <= R_IDLE;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
        end else begin
            ready_en_q <= ready_en_d;
            w_state_q  <= w_state_d;
            aw_held_q  <= aw_held_d;
            aw_reg_q   <= aw_reg_d;
            w_held_q   <= w_held_d;
            wdata_q    <= wdata_d;
            bresp_q    <= bresp_d;
            ovf_q      <= ovf_d;
            r_state_q  <= r_state_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

endmodule

// File: tb/tb_axil_txfifo_slave.sv
// Randomised bench for axil_txfifo_slave against a queue-based reference model.
module tb_axil_txfifo_slave;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst;
    logic [AW-1:0]   s_awaddr;
    logic            s_awvalid;
    logic            s_awready;
    logic [DW-1:0]   s_wdata;
    logic [DW/8-1:0] s_wstrb;
    logic            s_wvalid;
    logic            s_wready;
    logic [1:0]      s_bresp;
    logic            s_bvalid;
    logic            s_bready;
    logic [AW-1:0]   s_araddr;
    logic            s_arvalid;
    logic            s_arready;
    logic [DW-1:0]   s_rdata;
    logic [1:0]      s_rresp;
    logic            s_rvalid;
    logic            s_rready;
    logic [DW-1:0]   tx_data;
    logic            tx_valid;
    logic            tx_ready;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] model_q[$];
    logic          model_ovf = 1'b0;
    int            cons_mode = 0;

    always #5 clk = ~clk;

    axil_txfifo_slave #(
        .AW    (AW),
        .DW    (DW),
        .DEPTH (DEPTH),
        .LW    (LW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_awaddr  (s_awaddr),
        .s_awvalid (s_awvalid),
        .s_awready (s_awready),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_wvalid  (s_wvalid),
        .s_wready  (s_wready),
        .s_bresp   (s_bresp),
        .s_bvalid  (s_bvalid),
        .s_bready  (s_bready),
        .s_araddr  (s_araddr),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_rdata   (s_rdata),
        .s_rresp   (s_rresp),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready)
    );

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s = 32'(model_q.size());
        if (model_q.size() == 0)     s = s | 32'h0001_0000;
        if (model_q.size() == DEPTH) s = s | 32'h0002_0000;
        if (model_ovf)               s = s | 32'h0004_0000;
        return s;
    endfunction

    task automatic model_write(input logic [1:0] r, input logic [31:0] d, output logic [1:0] exp);
        exp = 2'b00;
        if (r == 2'd0) begin
            if (model_q.size() < DEPTH) model_q.push_back(d);
            else begin
                model_ovf = 1'b1;
                exp       = 2'b10;
            end
        end else if (r == 2'd2) begin
            if (d[0]) model_q.delete();
            if (d[1]) model_ovf = 1'b0;
        end else if (r == 2'd3) begin
            exp = 2'b10;
        end
    endtask

    // Consumer: acts just after the falling edge so the writer has already updated the model.
    initial begin
        tx_ready = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            case (cons_mode)
                0:       tx_ready = 1'b0;
                1:       tx_ready = 1'b1;
                default: tx_ready = ($urandom_range(0, 7) == 0);
            endcase
            if (!rst && tx_valid && tx_ready) begin
                checks++;
                if (model_q.size() == 0) begin
                    errors++;
                    $display("FAIL tx_unexpected: tx_data=%h but model queue is empty", tx_data);
                end else begin
                    if (tx_data !== model_q[0]) begin
                        errors++;
                        $display("FAIL tx_order: got %h expected %h", tx_data, model_q[0]);
                    end
                    void'(model_q.pop_front());
                end
            end
        end
    end

    task automatic axi_write(input logic [1:0] r, input logic [31:0] d, input int aw_dly, input int w_dly,
                             output logic [1:0] resp, output logic [1:0] exp, output int lat,
                             output logic txv_at_b);
        bit aw_done, w_done, aw_hs, w_hs;
        int cyc;
        aw_done  = 0;
        w_done   = 0;
        cyc      = 0;
        resp     = 2'bxx;
        exp      = 2'b00;
        lat      = -1;
        txv_at_b = 1'bx;
        s_awaddr = ($urandom() & 32'hFFFF_FFF3) | {28'd0, r, 2'b00};
        s_wdata  = d;
        s_wstrb  = 4'($urandom());
        while ((!aw_done || !w_done) && cyc < 100) begin
            s_awvalid = !aw_done && (cyc >= aw_dly);
            s_wvalid  = !w_done && (cyc >= w_dly);
            aw_hs     = s_awvalid && s_awready;
            w_hs      = s_wvalid && s_wready;
            @(negedge clk);
            cyc++;
            if (aw_hs) aw_done = 1;
            if (w_hs)  w_done = 1;
        end
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        s_bready  = 1'b1;
        for (int n = 0; n < 50; n++) begin
            if (s_bvalid) begin
                resp     = s_bresp;
                lat      = n;
                txv_at_b = tx_valid;
                model_write(r, d, exp);
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        s_bready = 1'b0;
        if (lat < 0) begin
            checks++;
            errors++;
            $display("FAIL b_timeout: no write response for reg %0d data %h", r, d);
        end
    endtask

    task automatic axi_read(input logic [1:0] r, output logic [31:0] data, output logic [1:0] resp,
                            output int lat);
        bit hs;
        int cyc;
        hs        = 0;
        cyc       = 0;
        lat       = -1;
        data      = 'x;
        resp      = 2'bxx;
        s_araddr  = ($urandom() & 32'hFFFF_FFF3) | {28'd0, r, 2'b00};
        s_arvalid = 1'b1;
        while (!hs && cyc < 50) begin
            hs = s_arready;
            @(negedge clk);
            cyc++;
        end
        s_arvalid = 1'b0;
        s_rready  = 1'b1;
        for (int n = 0; n < 50; n++) begin
            if (s_rvalid) begin
                data = s_rdata;
                resp = s_rresp;
                lat  = n;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        s_rready = 1'b0;
        if (lat < 0) begin
            checks++;
            errors++;
            $display("FAIL r_timeout: no read response for reg %0d", r);
        end
    endtask

    task automatic test_reset();
        logic [31:0] data;
        logic [1:0]  resp;
        int          lat;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({s_awready, s_wready, s_arready} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 000", {s_awready, s_wready, s_arready});
        end
        checks++;
        if ({s_bvalid, s_rvalid, tx_valid, s_bresp, s_rresp} !== 7'd0 || s_rdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: valids/resps %b rdata %h expected all zero",
                     {s_bvalid, s_rvalid, tx_valid, s_bresp, s_rresp}, s_rdata);
        end
        rst = 1'b0;
        model_q.delete();
        model_ovf = 1'b0;
        @(negedge clk);
        checks++;
        if ({s_awready, s_wready, s_arready} !== 3'b111) begin
            errors++;
            $display("FAIL ready_after_reset: got %b expected 111", {s_awready, s_wready, s_arready});
        end
        axi_read(2'd1, data, resp, lat);
        checks++;
        if (data !== 32'h0001_0000 || resp !== 2'b00) begin
            errors++;
            $display("FAIL reset_status: got %h/%b expected 00010000/00", data, resp);
        end
        checks++;
        if (lat !== 0) begin
            errors++;
            $display("FAIL read_latency: got %0d expected 0", lat);
        end
    endtask

    task automatic test_basic();
        logic [1:0]  resp, exp;
        logic [31:0] data;
        logic        txv;
        int          lat, n;
        cons_mode = 0;
        for (int i = 0; i < 3; i++) begin
            axi_write(2'd0, 32'hA5A5_0001 + 32'(i), 0, 0, resp, exp, lat, txv);
            checks++;
            if (resp !== exp) begin
                errors++;
                $display("FAIL basic_bresp: got %b expected %b", resp, exp);
            end
            checks++;
            if (lat !== 1) begin
                errors++;
                $display("FAIL write_latency: got %0d expected 1", lat);
            end
        end
        axi_read(2'd1, data, resp, lat);
        checks++;
        if (data !== model_status() || data[LW-1:0] !== 5'd3) begin
            errors++;
            $display("FAIL basic_status: got %h expected %h", data, model_status());
        end
        cons_mode = 1;
        n = 0;
        while (model_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (model_q.size() != 0 || tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_drain: tx_valid %b remaining %0d expected 0/0", tx_valid, model_q.size());
        end
        cons_mode = 0;
        @(negedge clk);
    endtask

    task automatic test_overflow();
        logic [1:0]  resp, exp;
        logic [31:0] data;
        logic        txv;
        int          lat;
        cons_mode = 0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            axi_write(2'd0, $urandom(), 0, 0, resp, exp, lat, txv);
            checks++;
            if (resp !== exp || (i == DEPTH && resp !== 2'b10) || (i < DEPTH && resp !== 2'b00)) begin
                errors++;
                $display("FAIL overflow_bresp[%0d]: got %b expected %b", i, resp, exp);
            end
        end
        axi_read(2'd1, data, resp, lat);
        checks++;
        if (data !== model_status() || data !== 32'h0006_0010) begin
            errors++;
            $display("FAIL full_status: got %h expected 00060010", data);
        end
        axi_write(2'd2, 32'h2, 0, 0, resp, exp, lat, txv);
        axi_read(2'd1, data, resp, lat);
        checks++;
        if (data !== model_status() || data !== 32'h0002_0010) begin
            errors++;
            $display("FAIL clear_ovf_status: got %h expected 00020010", data);
        end
        axi_write(2'd2, 32'h1, 0, 0, resp, exp, lat, txv);
        axi_read(2'd1, data, resp, lat);
        checks++;
        if (data !== 32'h0001_0000) begin
            errors++;
            $display("FAIL flush_after_full: got %h expected 00010000", data);
        end
    endtask

    task automatic test_skew();
        logic [1:0]  resp, exp;
        logic [31:0] d;
        logic        txv;
        int          lat, extra;
        cons_mode = 0;
        for (int k = 0; k < 2; k++) begin
            d = $urandom();
            axi_write(2'd0, d, (k == 0) ? 0 : 3, (k == 0) ? 3 : 0, resp, exp, lat, txv);
            extra    = 0;
            s_bready = 1'b1;
            repeat (5) begin
                @(negedge clk);
                if (s_bvalid) extra++;
            end
            s_bready = 1'b0;
            checks++;
            if (resp !== 2'b00 || extra != 0) begin
                errors++;
                $display("FAIL skew_bresp[%0d]: resp %b extra B %0d expected 00/0", k, resp, extra);
            end
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== d) begin
                errors++;
                $display("FAIL skew_data[%0d]: got %b/%h expected 1/%h", k, tx_valid, tx_data, d);
            end
            axi_write(2'd2, 32'h1, 0, 0, resp, exp, lat, txv);
        end
    endtask

    task automatic test_flush();
        logic [1:0]  resp, exp;
        logic [31:0] data;
        logic        txv;
        int          lat;
        cons_mode = 0;
        for (int i = 0; i < 5; i++) axi_write(2'd0, $urandom(), 0, 0, resp, exp, lat, txv);
        cons_mode = 1;
        axi_write(2'd2, 32'h1, 0, 0, resp, exp, lat, txv);
        checks++;
        if (resp !== exp || txv !== 1'b0) begin
            errors++;
            $display("FAIL flush_txvalid: resp %b tx_valid %b expected %b/0", resp, txv, exp);
        end
        cons_mode = 0;
        @(negedge clk);
        axi_read(2'd1, data, resp, lat);
        checks++;
        if (data !== 32'h0001_0000) begin
            errors++;
            $display("FAIL flush_status: got %h expected 00010000", data);
        end
    endtask

    task automatic test_hold_reset();
        logic [1:0]  resp, exp, b_snap, r_snap;
        logic [31:0] rd_snap, tx_snap;
        logic        txv, aw_hs, w_hs, ar_hs;
        int          lat, n;
        cons_mode = 0;
        axi_write(2'd0, $urandom(), 0, 0, resp, exp, lat, txv);
        axi_write(2'd0, $urandom(), 0, 0, resp, exp, lat, txv);
        s_bready  = 1'b0;
        s_rready  = 1'b0;
        s_awaddr  = 32'h0000_1000;
        s_wdata   = $urandom();
        s_araddr  = 32'h0000_2004;
        s_awvalid = 1'b1;
        s_wvalid  = 1'b1;
        s_arvalid = 1'b1;
        n = 0;
        while (!(s_bvalid && s_rvalid) && n < 30) begin
            aw_hs = s_awvalid && s_awready;
            w_hs  = s_wvalid && s_wready;
            ar_hs = s_arvalid && s_arready;
            @(negedge clk);
            n++;
            if (aw_hs) s_awvalid = 1'b0;
            if (w_hs)  s_wvalid = 1'b0;
            if (ar_hs) s_arvalid = 1'b0;
        end
        checks++;
        if (s_bvalid !== 1'b1 || s_rvalid !== 1'b1 || s_rdata !== 32'h0000_0002 || s_bresp !== 2'b00) begin
            errors++;
            $display("FAIL hold_start: bvalid %b rvalid %b rdata %h bresp %b expected 1/1/00000002/00",
                     s_bvalid, s_rvalid, s_rdata, s_bresp);
        end
        b_snap    = s_bresp;
        r_snap    = s_rresp;
        rd_snap   = s_rdata;
        tx_snap   = tx_data;
        s_awvalid = 1'b1;
        s_wvalid  = 1'b1;
        s_arvalid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if ({s_bvalid, s_rvalid, tx_valid} !== 3'b111 || s_bresp !== b_snap || s_rresp !== r_snap ||
                s_rdata !== rd_snap || tx_data !== tx_snap) begin
                errors++;
                $display("FAIL hold_stable[%0d]: valids %b rdata %h tx_data %h expected 111/%h/%h",
                         c, {s_bvalid, s_rvalid, tx_valid}, s_rdata, tx_data, rd_snap, tx_snap);
            end
            checks++;
            if ({s_awready, s_wready, s_arready} !== 3'b000) begin
                errors++;
                $display("FAIL hold_ready[%0d]: got %b expected 000", c, {s_awready, s_wready, s_arready});
            end
        end
        rst       = 1'b1;
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        s_arvalid = 1'b0;
        @(negedge clk);
        checks++;
        if ({s_bvalid, s_rvalid, tx_valid} !== 3'b000) begin
            errors++;
            $display("FAIL reset_abort: got %b expected 000", {s_bvalid, s_rvalid, tx_valid});
        end
        rst = 1'b0;
        model_q.delete();
        model_ovf = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [1:0]  resp, exp;
        logic [31:0] data, d;
        logic        txv;
        int          lat, kind, n;
        logic [1:0]  rr;
        cons_mode = 2;
        for (int i = 0; i < 90; i++) begin
            kind = $urandom_range(0, 19);
            if (kind < 17) begin
                d = $urandom();
                if (kind < 14)       rr = 2'd0;
                else if (kind == 14) begin
                    rr = 2'd2;
                    d  = {d[31:2], ($urandom_range(0, 3) == 0), d[1]};
                end
                else if (kind == 15) rr = 2'd1;
                else                 rr = 2'd3;
                axi_write(rr, d, $urandom_range(0, 2), $urandom_range(0, 2), resp, exp, lat, txv);
                checks++;
                if (resp !== exp) begin
                    errors++;
                    $display("FAIL rand_bresp[%0d]: reg %0d got %b expected %b", i, rr, resp, exp);
                end
            end else begin
                rr = (kind == 17) ? 2'd0 : (kind == 18) ? 2'd2 : 2'd3;
                axi_read(rr, data, resp, lat);
                checks++;
                if (data !== 32'd0 || resp !== ((rr == 2'd3) ? 2'b10 : 2'b00)) begin
                    errors++;
                    $display("FAIL rand_read[%0d]: reg %0d got %h/%b", i, rr, data, resp);
                end
            end
        end
        cons_mode = 0;
        repeat (2) @(negedge clk);
        axi_read(2'd1, data, resp, lat);
        checks++;
        if (data !== model_status()) begin
            errors++;
            $display("FAIL rand_status: got %h expected %h", data, model_status());
        end
        cons_mode = 1;
        n = 0;
        while (model_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (model_q.size() != 0 || tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL rand_drain: tx_valid %b remaining %0d expected 0/0", tx_valid, model_q.size());
        end
        cons_mode = 0;
    endtask

    initial begin
        rst       = 1'b1;
        s_awaddr  = '0;
        s_awvalid = 1'b0;
        s_wdata   = '0;
        s_wstrb   = '0;
        s_wvalid  = 1'b0;
        s_bready  = 1'b0;
        s_araddr  = '0;
        s_arvalid = 1'b0;
        s_rready  = 1'b0;
        test_reset();
        test_basic();
        test_overflow();
        test_skew();
        test_flush();
        test_hold_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/axil_txfifo_slave.md
Name: axil_txfifo_slave

Overview:
AXI-Lite slave endpoint that terminates the cpu_txfifo port of the AXI interconnect wrapper. The CPU writes transmit words into an internal synchronous FIFO and reads status through a small register map. The FIFO drains to the downstream transmit serializer over a valid/ready stream.

Parameters:
AW, 32, AXI-Lite address width (matches CPU_TXFIFO_AW)
DW, 32, AXI-Lite data width (matches CPU_TXFIFO_DW); also the FIFO word width
DEPTH, 16, FIFO depth in words; power of 2, minimum 2
LW, $clog2(DEPTH)+1, width of the level field

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
s_awaddr  in  AW  write address
s_awvalid  in  1  write address valid
s_awready  out  1  write address ready
s_wdata  in  DW  write data
s_wstrb  in  DW/8  write strobes
s_wvalid  in  1  write data valid
s_wready  out  1  write data ready
s_bresp  out  2  write response
s_bvalid  out  1  write response valid
s_bready  in  1  write response ready
s_araddr  in  AW  read address
s_arvalid  in  1  read address valid
s_arready  out  1  read address ready
s_rdata  out  DW  read data
s_rresp  out  2  read response
s_rvalid  out  1  read valid
s_rready  in  1  read ready
tx_data  out  DW  FIFO head word
tx_valid  out  1  FIFO not empty
tx_ready  in  1  consumer accepts head word

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: all ready, valid and resp outputs are 0. rdata is 0. FIFO is empty, overflow is 0, tx_valid is 0. After reset is released, awready, wready and arready rise on the first cycle.
- Address decode uses s_awaddr[3:2] and s_araddr[3:2]. The upper bits are ignored.
  - 0 = DATA: write only; a read returns 0.
  - 1 = STATUS: read only. Bits [LW-1:0] = level, [16] = empty, [17] = full, [18] = overflow (sticky).
  - 2 = CTRL: write only. Bit 0 = flush, bit 1 = clear overflow. Both are self-clearing pulses.
  - 3 = unmapped: response SLVERR (2'b10).
- Write FSM states: W_IDLE, W_RESP.
  - AW and W are captured independently. awready drops once AW is latched; wready drops once W is latched.
  - The cycle after both are held, the register action is performed and the FSM moves to W_RESP with bvalid=1.
  - bvalid stays 1 until bready. On the handshake, the FSM returns to W_IDLE and awready and wready re-assert the next cycle.
  - Only one write is outstanding at a time.
  - A write with AW and W valid in the same cycle gives bvalid 2 cycles after the handshake cycle.
- DATA write rules:
  - wstrb is ignored; the full word is pushed.
  - If the FIFO is full, the word is dropped, bresp=SLVERR and overflow is set.
  - Otherwise the word is pushed and bresp=OKAY.
- CTRL write rules: flush empties the FIFO in one cycle and suppresses tx_valid on the following cycle. The flush takes priority over a same-cycle pop.
- Read FSM states: R_IDLE, R_DATA.
  - On the ar handshake, rdata and rresp are registered and rvalid=1 the next cycle.
  - Both are held stable until rready. arready is 0 while in R_DATA.
  - STATUS reflects state at the ar handshake cycle.
- Read and write channels operate concurrently and independently.
- FIFO rules:
  - Push and pop in the same cycle keep the level unchanged. A push when full (no same-cycle pop) is an overflow; a same-cycle pop when full makes the push legal.
  - Pointers wrap modulo DEPTH. Level ranges 0..DEPTH.
  - tx_data is valid whenever tx_valid=1 and is held stable until tx_ready.
- Reset mid-transaction aborts any pending B or R response (valid drops) and empties the FIFO.

Decomposition:
- Package txfifo_pkg holds:
  - register offsets REG_DATA, REG_STATUS, REG_CTRL
  - resp codes RESP_OKAY=2'b00 and RESP_SLVERR=2'b10
  - STATUS bit positions
  - enum types for the write and read FSM states
- One sub-module, sync_fifo, parameterised by DW and DEPTH:
  - inputs push, pop, flush
  - outputs dout, empty, full, level

Test Plan:
- Reset, then read STATUS -> rdata=0x0001_0000 (empty=1, level=0), rresp=OKAY.
- Write 0xA5A5_0001, 0xA5A5_0002, 0xA5A5_0003 to DATA with tx_ready=0; read STATUS -> level=3. Raise tx_ready -> tx_data emits the 3 words in order, then tx_valid=0.
- Write 17 words with tx_ready=0 at DEPTH=16 -> the first 16 get bresp=OKAY, the 17th gets SLVERR. STATUS = full=1, overflow=1, level=16. Write CTRL=0x2 -> overflow=0.
- Give AW 3 cycles before W, and separately W before AW -> exactly one B response each, with the correct data pushed.
- With the FIFO holding 5 words, write CTRL=0x1 while tx_ready=1 -> tx_valid=0 the following cycle and STATUS level=0.
- Hold bready=0 and rready=0 for 10 cycles -> bvalid, rvalid, rdata and tx_data all stable, no new handshakes accepted. Assert rst mid-hold -> all valids are 0 the next cycle.
